// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: READ/WRITE alternation per 32-bit word, done pulse on completion or rejection.
// Optional fill mode (constant pattern, one cycle per word) is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [31:0]       fill_pattern,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              fill_q, fill_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fill_req;
  logic [31:0]       fill_pat;
  logic              bad_start;

`ifdef MEM_COPY_FILL_EN
  assign fill_req = fill;
  assign fill_pat = fill_pattern;
`else
  assign fill_req = 1'b0;
  assign fill_pat = 32'd0;
`endif

  // Source alignment is irrelevant when filling, since nothing is read.
  assign bad_start = (dst_addr[1:0] != 2'b00) ||
                     (!fill_req && (src_addr[1:0] != 2'b00));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    fill_d     = fill_q;
    err_d      = err_q;
    mem_addr_d = '0;
    mem_wd_d   = '0;
    mem_we_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = len_words;
          fill_d = fill_req;
          data_d = fill_req ? fill_pat : 32'd0;
          err_d  = bad_start;
          if (bad_start || (len_words == '0)) state_d = S_FINISH;
          else if (fill_req)                  state_d = S_WRITE;
          else                                state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = mem_rd;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d = dst_q + ADDR_W'(4);
        if (!fill_q) src_d = src_q + ADDR_W'(4);
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = S_FINISH;
        else if (fill_q)        state_d = S_WRITE;
        else                    state_d = S_READ;
      end
      default: state_d = S_IDLE;
    endcase

    // Port outputs are registered from the next state so mem_we is a clean flop output.
    unique case (state_d)
      S_READ: begin
        mem_addr_d = src_d;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_addr_d = dst_d;
        mem_wd_d   = data_d;
        mem_we_d   = 1'b1;
        busy_d     = 1'b1;
      end
      S_FINISH: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      fill_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: directed scenarios plus random transfers against a word-array reference memory.
// Handshake: start is a one-cycle pulse accepted only when idle; each accepted start yields exactly one done pulse.
module tb_mem_copy_engine;
  localparam int LEN_W  = 16;
  localparam int ADDR_W = 32;
  localparam logic [1:0] ST_READ = 2'd1;

  typedef struct {
    int   start_cyc;
    int   lat;
    int   busy_n;
    logic err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len_words = '0;
`ifdef MEM_COPY_FILL_EN
  logic              fill_s = 1'b0;
  logic [31:0]       fill_pat_s = '0;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              mem_we;
  logic [31:0]       mem_rd;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;

  mem_copy_engine #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
`ifdef MEM_COPY_FILL_EN
    .fill(fill_s), .fill_pattern(fill_pat_s),
`endif
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset / memory model
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign mem_rd = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      check("we_outside_busy", {31'd0, mem_we & ~busy}, 32'd0);
      check("we_in_read", {31'd0, mem_we & (dbg_state == ST_READ)}, 32'd0);
      if (!busy) begin
        check("idle_addr", mem_addr, 32'd0);
        check("idle_wd", mem_wd, 32'd0);
      end
      if (done) begin
        check("done_while_busy", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
          check("err", {31'd0, err}, {31'd0, e.err});
          check("mem_contents", 32'(mem_diff()), 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // driver: apply the reference model, push expectation, pulse start
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int len,
                       input logic f, input logic [31:0] pat);
    exp_t e;
    logic bad;
    logic [31:0] sa, da;
    bad = (d[1:0] != 2'b00) || (!f && (s[1:0] != 2'b00));
    if (!bad) begin
      for (int i = 0; i < len; i++) begin
        sa = s + 32'(4 * i);
        da = d + 32'(4 * i);
        ref_mem[da[9:2]] = f ? pat : ref_mem[sa[9:2]];
      end
    end
    e.err    = bad;
    e.lat    = (bad || len == 0) ? 2 : (f ? 2 + len : 2 + 2 * len);
    e.busy_n = (bad || len == 0) ? 0 : (f ? len : 2 * len);
    @(posedge clk); #1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = LEN_W'(len);
`ifdef MEM_COPY_FILL_EN
    fill_s = f; fill_pat_s = pat;
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, t;
    logic [31:0] rs, rd;
    int rl;
    logic rf;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wd", mem_wd, 32'd0);

    // three-word copy
    mem[4] = 32'h11111111; mem[5] = 32'h22222222; mem[6] = 32'h33333333;
    ref_mem[4] = mem[4]; ref_mem[5] = mem[5]; ref_mem[6] = mem[6];
    issue(32'h10, 32'h40, 3, 1'b0, 32'd0);
    wait_done();
    check("copy3_w0", mem[16], 32'h11111111);
    check("copy3_w1", mem[17], 32'h22222222);
    check("copy3_w2", mem[18], 32'h33333333);

    // zero length
    issue(32'h20, 32'h60, 0, 1'b0, 32'd0);
    wait_done();

    // misaligned source: rejected, err sticky until next aligned start
    issue(32'h12, 32'h40, 5, 1'b0, 32'd0);
    wait_done();
    repeat (3) begin
      @(negedge clk);
      check("err_sticky", {31'd0, err}, 32'd1);
    end
    issue(32'h30, 32'h2C4, 2, 1'b0, 32'd0);
    wait_done();
    check("err_cleared", {31'd0, err}, 32'd0);

    // reset after the second write of a four-word copy; reset beats a simultaneous start
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len_words = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wc = 0; t = 0;
    while (wc < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (mem_we) wc++;
    end
    check("rst_two_writes_seen", 32'(wc), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; src_addr = 32'h0; dst_addr = 32'h10; len_words = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    ref_mem[128] = ref_mem[64];
    ref_mem[129] = ref_mem[65];
    repeat (6) @(posedge clk);
    check("abort_mem", 32'(mem_diff()), 32'd0);

    // start while busy is ignored
    issue(32'h300, 32'h340, 5, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; src_addr = 32'h8; dst_addr = 32'h3C0; len_words = 16'd7;
    @(posedge clk); #1 start = 1'b0;
    wait_done();

    // address wrap and forward-overlap copy
    issue(32'hFFFF_FFF8, 32'h380, 4, 1'b0, 32'd0);
    wait_done();
    issue(32'h20, 32'h24, 6, 1'b0, 32'd0);
    wait_done();
    check("overlap_smear", mem[14], mem[8]);

`ifdef MEM_COPY_FILL_EN
    issue(32'h13, 32'h80, 2, 1'b1, 32'hDEADBEEF);
    wait_done();
    check("fill_w0", mem[32], 32'hDEADBEEF);
    check("fill_w1", mem[33], 32'hDEADBEEF);
`endif

    // random transfers
    for (int n = 0; n < 40; n++) begin
      rs = $urandom; rd = $urandom;
      if ($urandom_range(0, 5) != 0) rs[1:0] = 2'b00;
      if ($urandom_range(0, 5) != 0) rd[1:0] = 2'b00;
      rl = $urandom_range(0, 12);
      rf = 1'b0;
`ifdef MEM_COPY_FILL_EN
      rf = ($urandom_range(0, 3) == 0);
`endif
      issue(rs, rd, rl, rf, $urandom);
      wait_done();
    end

    repeat (4) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the word-count input.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of the memory port.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a transfer, sampled in IDLE only.
REQ-006 SHALL have port src_addr, input, ADDR_W, the source byte address, sampled with start.
REQ-007 SHALL have port dst_addr, input, ADDR_W, the destination byte address, sampled with start.
REQ-008 SHALL have port len_words, input, LEN_W, the number of 32-bit words to copy, sampled with start.
REQ-009 SHALL have port mem_addr, output, ADDR_W, the byte address driven to the data-memory address input.
REQ-010 SHALL have port mem_wd, output, 32, the write data, with byte 0 in bits [7:0].
REQ-011 SHALL have port mem_we, output, 1, the write enable to data memory.
REQ-012 SHALL have port mem_rd, input, 32, the combinational read data returned for mem_addr in the same cycle.
REQ-013 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a transfer ends, whether it completed or was rejected.
REQ-015 SHALL have port err, output, 1, sticky: set when a rejected start is accepted, cleared by the next accepted start or by reset.

Function
REQ-016 SHALL implement the states IDLE, READ, WRITE and FINISH.
REQ-017 SHALL, in IDLE with start=1, latch src_addr, dst_addr and len_words, then go to READ if len_words is nonzero and both addresses have bits [1:0]=0; otherwise it SHALL go to FINISH.
REQ-018 SHALL set err=1 on an accepted start if either address has bits [1:0] nonzero, and set err=0 if both are aligned.
REQ-019 SHALL, in READ, drive mem_addr=src pointer and mem_we=0, capture mem_rd into a data register at the clock edge, and then go to WRITE.
REQ-020 SHALL, in WRITE, drive mem_addr=dst pointer, mem_wd=data register and mem_we=1; at the edge it SHALL add 4 to both pointers and decrement the remaining count.
REQ-021 SHALL, from WRITE, go to FINISH when the remaining count reaches 0 and to READ otherwise, so each word costs exactly 2 cycles.
REQ-022 SHALL, in FINISH, assert done=1 for one cycle and return to IDLE; busy is 0 in FINISH.
REQ-023 SHALL keep busy=1 in READ and WRITE only.
REQ-024 SHALL ignore start whenever the block is not in IDLE.
REQ-025 SHALL wrap pointer increments modulo 2^ADDR_W without flagging an error.
REQ-026 SHALL copy forward, word by word; when the source and destination ranges overlap with dst>src, words already overwritten SHALL be re-read, and this result is the defined behaviour.
REQ-027 SHALL keep mem_we=0 in every state except WRITE, with no glitch-driven write path.
REQ-028 SHALL hold mem_addr=0 and mem_wd=0 while in IDLE or FINISH.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, enter IDLE and clear busy, done, err, mem_we, mem_addr, mem_wd, the pointers, the count and the data register.
REQ-030 SHALL, on reset during a transfer, abort immediately with no further write, produce no done pulse, and leave already-written words in place.
REQ-031 SHALL give rst priority over start in the same cycle.

Configuration
REQ-032 SHALL, when macro MEM_COPY_FILL_EN is defined, add input fill (1 bit, sampled with start) and input fill_pattern (32 bits, sampled with start).
REQ-033 SHALL, when fill=1 under MEM_COPY_FILL_EN, skip READ: it SHALL go IDLE to WRITE, write fill_pattern to each destination word, apply the src alignment check not at all, take 1 cycle per word, and leave the src pointer unchanged.
REQ-034 SHALL, when MEM_COPY_FILL_EN is undefined, have no fill ports and behave as REQ-016 to REQ-031.

Verification
REQ-035 SHALL be covered by this scenario: memory[0x10..0x1B] = 0x11111111, 0x22222222, 0x33333333; start with src=0x10, dst=0x40, len=3 -> memory[0x40..0x4B] holds the same three words, busy is high for 6 cycles, done pulses once in cycle 8 after start, and err=0.
REQ-036 SHALL be covered by this scenario: start with len=0 -> no write occurs, done pulses in the 2nd cycle, busy stays 0, and err=0.
REQ-037 SHALL be covered by this scenario: start with src=0x12 -> no write occurs, done pulses, and err=1 until the next aligned start.
REQ-038 SHALL be covered by this scenario: rst=1 after the 2nd write of a len=4 copy -> exactly 2 destination words change, busy=0 and done=0 on the next cycle.
REQ-039 SHALL be covered by this scenario: a start pulse while busy with different addresses -> it is ignored and the original transfer completes unchanged.
REQ-040 SHALL be covered by this scenario: with MEM_COPY_FILL_EN defined, fill=1, pattern=0xDEADBEEF, dst=0x80, len=2 -> words 0x80 and 0x84 hold 0xDEADBEEF, busy is high for 2 cycles, and mem_we never rises in a READ state.
